mcpu_ram_arbiter: RTL

MCPU_RAM_ARBITER -- requirements
Module: mcpu_ram_arbiter

---
 rtl/mcpu_ram_pkg.sv | 23 ++
 rtl/mcpu_rr_pick2.sv | 30 +++
 rtl/mcpu_ram_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mcpu_ram_pkg.sv
// ---------------------------------------------------------------------------
// mcpu_ram_pkg : shared defaults, FSM encoding and port IDs for the RAM arbiter
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mcpu_ram_pkg;

  localparam int WORD_SIZE_DEF  = 8;
  localparam int ADDR_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_RSP  = 2'd2
  } state_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mcpu_rr_pick2.sv
// ---------------------------------------------------------------------------
// mcpu_rr_pick2 : combinational two-way round-robin pick (fetch vs data port)
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mcpu_rr_pick2
  import mcpu_ram_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last_grant,
  output logic grant,
  output logic grant_valid
);

  always_comb begin
    grant_valid = req_i | req_d;
    grant       = PORT_I;
    if (req_i && req_d) begin
      // On a tie the port that lost the previous grant goes first.
      grant = (last_grant == PORT_I) ? PORT_D : PORT_I;
    end else if (req_d) begin
      grant = PORT_D;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mcpu_ram_arbiter.sv
// ---------------------------------------------------------------------------
// mcpu_ram_arbiter : shares one single-port RAM between fetch and data ports
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mcpu_ram_arbiter
  import mcpu_ram_pkg::*;
#(
  parameter int WORD_SIZE  = WORD_SIZE_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_ack,
  output logic [WORD_SIZE-1:0]  i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [WORD_SIZE-1:0]  d_wdata,
  output logic                  d_ack,
  output logic [WORD_SIZE-1:0]  d_rdata,
  output logic                  ram_we,
  output logic                  ram_re,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [WORD_SIZE-1:0]  ram_wdata,
  input  logic [WORD_SIZE-1:0]  ram_rdata,
  output logic                  busy
);

  state_e                  state_q,      state_d;
  logic                    last_grant_q, last_grant_d;
  logic                    gnt_q,        gnt_d;
  logic                    ram_we_q,     ram_we_d;
  logic                    ram_re_q,     ram_re_d;
  logic [ADDR_WIDTH-1:0]   ram_addr_q,   ram_addr_d;
  logic [WORD_SIZE-1:0]    ram_wdata_q,  ram_wdata_d;
  logic                    i_ack_q,      i_ack_d;
  logic                    d_ack_q,      d_ack_d;
  logic [WORD_SIZE-1:0]    i_rdata_q,    i_rdata_d;
  logic [WORD_SIZE-1:0]    d_rdata_q,    d_rdata_d;
  logic                    busy_q,       busy_d;

  logic pick;
  logic pick_valid;

  mcpu_rr_pick2 u_pick (
    .req_i       (i_req),
    .req_d       (d_req),
    .last_grant  (last_grant_q),
    .grant       (pick),
    .grant_valid (pick_valid)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    ram_we_d     = ram_we_q;
    ram_re_d     = ram_re_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    i_ack_d      = 1'b0;
    d_ack_d      = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d      = ST_ACC;
          last_grant_d = pick;
          gnt_d        = pick;
          if (pick == PORT_I) begin
            ram_addr_d = i_addr;
            ram_re_d   = 1'b1;
          end else begin
            ram_addr_d = d_addr;
            if (d_we) begin
              ram_we_d    = 1'b1;
              ram_wdata_d = d_wdata;
            end else begin
              ram_re_d = 1'b1;
            end
          end
        end
      end
      ST_ACC: begin
        // RAM commits the write / presents read data at this edge.
        state_d  = ST_RSP;
        ram_we_d = 1'b0;
        ram_re_d = 1'b0;
        if (gnt_q == PORT_I) begin
          i_ack_d   = 1'b1;
          i_rdata_d = ram_rdata;
        end else begin
          d_ack_d = 1'b1;
          if (!ram_we_q) begin
            d_rdata_d = ram_rdata;
          end
        end
      end
      ST_RSP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        ram_we_d = 1'b0;
        ram_re_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= PORT_D;
      gnt_q        <= PORT_I;
      ram_we_q     <= 1'b0;
      ram_re_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      ram_we_q     <= ram_we_d;
      ram_re_q     <= ram_re_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      i_ack_q      <= i_ack_d;
      d_ack_q      <= d_ack_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign i_ack     = i_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_rdata   = d_rdata_q;
  assign ram_we    = ram_we_q;
  assign ram_re    = ram_re_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire
